// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter
//   Round-robin arbiter with bus-hold and timeout for a shared single-master
//   bus. The owner keeps the grant while it holds its request, up to MAX_HOLD
//   consecutive cycles (0 = unlimited). Ownership then passes to the next
//   requester in circular order, always with one dead cycle between owners.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   req      per-requester level-sensitive request (req[i] <-> gnt[i])
//   gnt      one-hot-or-zero grant, registered
//   gnt_id   index of the current owner, 0 when the bus is idle
//   busy     high while any gnt bit is high
//   timeout  one-cycle pulse in the dead cycle after a forced release
module rr_bus_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    localparam int IW      = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          busy,
    output logic          timeout
);

    // Counter must be at least one bit wide even when the timeout is disabled
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   ptr_r;
    logic [IW-1:0]   owner_r;
    logic [HW-1:0]   hold_cnt_r;

    logic            win_found_s;
    logic [IW-1:0]   win_idx_s;
    int              cand_s;
    logic            at_limit_s;

    // Explicit modulo-N increment; plain truncation would be wrong for non-power-of-2 N
    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        logic [IW-1:0] nxt;
        if (idx == IW'(N - 1)) begin
            nxt = {IW{1'b0}};
        end else begin
            nxt = idx + IW'(1'b1);
        end
        return nxt;
    endfunction

    // Circular priority search starting at ptr; the first hit in search order wins
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IW{1'b0}};
        cand_s      = 32'sd0;
        for (int k = 32'sd0; k < N; k++) begin
            cand_s = int'(ptr_r) + k;
            cand_s = (cand_s >= N) ? (cand_s - N) : cand_s;
            if (req[cand_s] && !win_found_s) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s[IW-1:0];
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Hold budget exhausted (never true when the timeout is disabled)
    always_comb begin
        if (MAX_HOLD != 0) begin
            at_limit_s = (hold_cnt_r >= HOLD_MAX);
        end else begin
            at_limit_s = 1'b0;
        end
    end

    // Arbitration FSM with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            ptr_r      <= {IW{1'b0}};
            owner_r    <= {IW{1'b0}};
            hold_cnt_r <= {HW{1'b0}};
            gnt        <= {N{1'b0}};
            gnt_id     <= {IW{1'b0}};
            busy       <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    timeout <= 1'b0;
                    if (win_found_s) begin
                        state_r    <= GRANT;
                        owner_r    <= win_idx_s;
                        hold_cnt_r <= HW'(1'b1);
                        gnt        <= {{(N-1){1'b0}}, 1'b1} << win_idx_s;
                        gnt_id     <= win_idx_s;
                        busy       <= 1'b1;
                    end else begin
                        gnt        <= {N{1'b0}};
                        gnt_id     <= {IW{1'b0}};
                        busy       <= 1'b0;
                    end
                end
                GRANT: begin
                    if (req[owner_r] && !at_limit_s) begin
                        // Saturate so an unlimited hold cannot wrap the counter
                        if (hold_cnt_r != {HW{1'b1}}) begin
                            hold_cnt_r <= hold_cnt_r + HW'(1'b1);
                        end else begin
                            hold_cnt_r <= hold_cnt_r;
                        end
                        timeout <= 1'b0;
                    end else begin
                        // Release or forced release: dead cycle, pointer moves past owner
                        state_r    <= IDLE;
                        ptr_r      <= wrap_inc(owner_r);
                        hold_cnt_r <= {HW{1'b0}};
                        gnt        <= {N{1'b0}};
                        gnt_id     <= {IW{1'b0}};
                        busy       <= 1'b0;
                        timeout    <= req[owner_r];
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    ptr_r      <= {IW{1'b0}};
                    owner_r    <= {IW{1'b0}};
                    hold_cnt_r <= {HW{1'b0}};
                    gnt        <= {N{1'b0}};
                    gnt_id     <= {IW{1'b0}};
                    busy       <= 1'b0;
                    timeout    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb_rr_bus_arbiter
//   Directed bench for rr_bus_arbiter (N=4, MAX_HOLD=8). A behavioural model
//   tracks owner/pointer/hold-time as plain integers and is compared with the
//   DUT outputs on every falling edge; directed scenarios add literal checks.
module tb_rr_bus_arbiter;

    localparam int N    = 4;
    localparam int MAXH = 8;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         timeout;

    int tests = 0;
    int fails = 0;

    rr_bus_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_owner;   // -1 when nobody owns the bus
    int m_ptr;
    int m_cnt;
    int m_to;

    function automatic int pick(input logic [N-1:0] r, input int p);
        int w = -1;
        for (int k = 0; k < N; k++) begin
            int c = (p + k) % N;
            if (r[c] && w < 0) w = c;
        end
        return w;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_owner <= -1;
            m_ptr   <= 0;
            m_cnt   <= 0;
            m_to    <= 0;
        end else if (m_owner < 0) begin
            m_to <= 0;
            if (pick(req, m_ptr) >= 0) begin
                m_owner <= pick(req, m_ptr);
                m_cnt   <= 1;
            end
        end else if (req[m_owner] && (MAXH == 0 || m_cnt < MAXH)) begin
            m_to  <= 0;
            m_cnt <= m_cnt + 1;
        end else begin
            m_to    <= req[m_owner] ? 1 : 0;
            m_ptr   <= (m_owner + 1) % N;
            m_owner <= -1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("model_gnt",     int'(gnt),     (m_owner < 0) ? 0 : (1 << m_owner));
            chk("model_gnt_id",  int'(gnt_id),  (m_owner < 0) ? 0 : m_owner);
            chk("model_busy",    int'(busy),    (m_owner < 0) ? 0 : 1);
            chk("model_timeout", int'(timeout), m_to);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        req = 4'b0000;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_gnt",     int'(gnt),     0);
        chk("rst_gnt_id",  int'(gnt_id),  0);
        chk("rst_busy",    int'(busy),    0);
        chk("rst_timeout", int'(timeout), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        #1 rst = 1'b0;
        #1;
        chk("init_gnt",  int'(gnt),  0);
        chk("init_busy", int'(busy), 0);
        cyc(2);
        rst = 1'b1;

        // Single request: four granted cycles, then release moves ptr to 1
        req = 4'b0001;
        cyc();
        chk("t1_gnt",    int'(gnt),    1);
        chk("t1_gnt_id", int'(gnt_id), 0);
        chk("t1_busy",   int'(busy),   1);
        cyc(3);
        chk("t1_gnt_held", int'(gnt), 1);
        req = 4'b0000;
        cyc();
        chk("t1_gnt_rel",  int'(gnt),        0);
        chk("t1_busy_rel", int'(busy),       0);
        chk("t1_ptr",      int'(dut.ptr_r),  1);
        chk("t1_no_to",    int'(timeout),    0);

        // Simultaneous requests 1 and 2 after reset
        do_reset();
        req = 4'b0110;
        cyc();
        chk("t2_first",    int'(gnt),    4'b0010);
        chk("t2_first_id", int'(gnt_id), 1);
        cyc(2);
        chk("t2_held", int'(gnt), 4'b0010);
        req = 4'b0100;
        cyc();
        chk("t2_dead", int'(gnt), 0);
        cyc();
        chk("t2_second",    int'(gnt),    4'b0100);
        chk("t2_second_id", int'(gnt_id), 2);
        req = 4'b0000;
        cyc(2);

        // Bus busy: req[0] arrives while req[3] owns the bus
        do_reset();
        req = 4'b1000;
        cyc();
        chk("t3_own", int'(gnt), 4'b1000);
        cyc();
        req = 4'b1001;
        cyc();
        chk("t3_ignore0", int'(gnt), 4'b1000);
        cyc(2);
        chk("t3_still", int'(gnt), 4'b1000);
        req = 4'b0001;
        cyc();
        chk("t3_dead", int'(gnt), 0);
        cyc();
        chk("t3_next", int'(gnt), 4'b0001);
        req = 4'b0000;
        cyc(2);

        // Timeout with both 1 and 2 held continuously
        do_reset();
        req = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t4_g1", int'(gnt), 4'b0010);
            chk("t4_to_low", int'(timeout), 0);
        end
        cyc();
        chk("t4_dead1", int'(gnt),     0);
        chk("t4_to1",   int'(timeout), 1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("t4_g2", int'(gnt), 4'b0100);
        end
        cyc();
        chk("t4_dead2", int'(gnt),     0);
        chk("t4_to2",   int'(timeout), 1);
        cyc();
        chk("t4_back1", int'(gnt), 4'b0010);
        req = 4'b0000;
        cyc();
        chk("t4_rel_no_to", int'(timeout), 0);
        cyc();

        // Fairness: 8-cycle grants in order 0,1,2,3,... separated by dead cycles
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 50; c++) begin
            cyc();
            chk("t5_order", int'(gnt), ((c % 9) < 8) ? (1 << ((c / 9) % 4)) : 0);
        end
        req = 4'b0000;
        cyc(2);

        // Reset asserted mid-grant, then ptr is back at 0
        do_reset();
        req = 4'b0100;
        cyc();
        chk("t6_own", int'(gnt), 4'b0100);
        #2 rst = 1'b0;
        #1;
        chk("t6_async_gnt",    int'(gnt),    0);
        chk("t6_async_busy",   int'(busy),   0);
        chk("t6_async_gnt_id", int'(gnt_id), 0);
        cyc();
        req = 4'b1001;
        rst = 1'b1;
        cyc();
        chk("t6_after_rst", int'(gnt),    4'b0001);
        chk("t6_after_id",  int'(gnt_id), 0);
        req = 4'b0000;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rr_bus_arbiter.md
# rr_bus_arbiter

Round-robin arbiter with bus-hold and timeout for the shared single-master bus used by the four-requester arbitration path. Each requester holds its request for as long as it needs the bus. The owner keeps the grant until it drops its request or exhausts its maximum hold budget. Ownership then rotates fairly, with one dead cycle between owners so bus drivers never overlap.

## Interface

- N, default 4: number of requesters, 2..16.
- MAX_HOLD, default 8: maximum consecutive grant cycles per ownership. 0 disables the timeout.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N  per-requester request, level-sensitive; req[i] corresponds to gnt[i].
- gnt  output  N  one-hot-or-zero grant, registered.
- gnt_id  output  max(1,$clog2(N))  index of the current owner; 0 when no owner.
- busy  output  1  high while any gnt bit is high.
- timeout  output  1  one-cycle pulse in the first cycle after an ownership forcibly ended by MAX_HOLD.

## Operation

- Two states, IDLE and GRANT. Internal state:
  - ptr, width of gnt_id: highest-priority candidate.
  - owner: current owner index.
  - hold_cnt, width $clog2(MAX_HOLD+1): cycles of the current grant.
- Arbitration happens only in IDLE.
  - The winner is the first i with req[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - The search index wraps modulo N. For non-power-of-2 N, the wrap is computed explicitly rather than by truncation.
- IDLE, with any req high at the edge:
  - Go to GRANT.
  - gnt[winner]=1, gnt_id=winner, busy=1, hold_cnt=1.
- IDLE, with no req high: stay in IDLE; all outputs 0.
- GRANT, with req[owner]=1 and (MAX_HOLD=0 or hold_cnt<MAX_HOLD):
  - Stay in GRANT.
  - hold_cnt increments; it saturates when MAX_HOLD=0.
- GRANT, release: req[owner]=0 at the edge.
  - Go to IDLE; gnt, gnt_id and busy become 0.
  - ptr = (owner+1) mod N.
- GRANT, timeout: req[owner]=1 and hold_cnt==MAX_HOLD at the edge.
  - Same as release, and timeout=1 for that one cycle.
  - The preempted requester must wait its turn, because ptr has moved past it.
- Requests from non-owners during GRANT are ignored; they do not alter ptr or owner.
- A request that rises and falls entirely within a GRANT period is never granted. There is no request latching.
- gnt is never multi-hot. gnt and busy are always consistent.

## Timing

- Reset (rst=0): asynchronous.
  - gnt=0, gnt_id=0, busy=0, timeout=0.
  - State IDLE, ptr=0, owner=0, hold_cnt=0.
  - Deassertion is synchronized externally; the first active edge after rst=1 may arbitrate.
- Grant latency: request sampled high at edge k gives gnt high after edge k, provided the arbiter is in IDLE at edge k.
- Release latency: req[owner] sampled low at edge m gives gnt low after edge m.
- Turnaround: after release or timeout at edge m, the earliest next grant is at edge m+1. This guarantees exactly one cycle with gnt=0 between owners.
- Grant duration with timeout: at most MAX_HOLD cycles.
- Under a continuous request, gnt[i] is high for exactly MAX_HOLD cycles. The timeout pulse coincides with the dead cycle.
- Reset asserted mid-grant: gnt drops immediately, without waiting for a clock. ptr returns to 0.
- Simultaneous release by the owner and new requests at the same edge: go to IDLE. New requests are arbitrated at the next edge with the updated ptr.

## Test plan

- Single request, N=4, MAX_HOLD=8: req[0] goes high at edge 5 and low at edge 9.
  - Required: gnt=0001 for cycles after edges 5..8; gnt=0000 after edge 9; ptr=1.
- Simultaneous requests after reset (ptr=0): req[2] and req[1] rise together and are held.
  - Required: gnt=0010 first. After req[1] drops: one cycle of 0000, then gnt=0100.
- Bus busy: req[3] is granted; req[0] rises two cycles later; req[3] is held 5 cycles.
  - Required: gnt stays 1000 and ignores req[0]. After req[3] drops: one idle cycle, then gnt=0001.
- Timeout, MAX_HOLD=8: req[1] and req[2] are both held continuously from reset.
  - Required: gnt=0010 for exactly 8 cycles; then 0000 with timeout=1; then 0100 for 8 cycles; then gnt=0010 again.
- Fairness: all four requests held for 50 cycles.
  - Required: grant order 0,1,2,3,0,1,...; each grant lasts 8 cycles, separated by single dead cycles; no requester is starved.
- Reset mid-operation: rst is pulled low between clock edges while gnt=0100.
  - Required: gnt, busy and gnt_id are 0 before the next edge. After rst=1 with req[3] and req[0] both high, gnt=0001, because ptr=0.
